// File: rtl/cmp_serial_rx_pkg.sv
// Shared types for the digit-serial comparator: FSM state encoding and digit width.
package cmp_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/cmp_serial_rx_if.sv
// Handshake and result bundle for cmp_serial_rx; abort exists only with CMP_SERIAL_ABORT_EN.
interface cmp_serial_rx_if;
  import cmp_pkg::*;

  logic               start;
  logic               eq_in;
  logic               gt_in;
  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic               dig_valid;
  logic               dig_ready;
  logic               busy;
  logic               done;
  logic               EQ;
  logic               GT;
`ifdef CMP_SERIAL_ABORT_EN
  logic               abort;

  modport master (
    output start, eq_in, gt_in, a_dig, b_dig, dig_valid, abort,
    input  dig_ready, busy, done, EQ, GT
  );

  modport slave (
    input  start, eq_in, gt_in, a_dig, b_dig, dig_valid, abort,
    output dig_ready, busy, done, EQ, GT
  );
`else
  modport master (
    output start, eq_in, gt_in, a_dig, b_dig, dig_valid,
    input  dig_ready, busy, done, EQ, GT
  );

  modport slave (
    input  start, eq_in, gt_in, a_dig, b_dig, dig_valid,
    output dig_ready, busy, done, EQ, GT
  );
`endif

endinterface

// File: rtl/cmp_serial_rx_cmp2_cell.sv
// Combinational 2-bit magnitude cascade cell: a higher digit overrides the seed.
module cmp2_cell (
  input  logic a1,
  input  logic a0,
  input  logic b1,
  input  logic b0,
  input  logic eq,
  input  logic gt,
  output logic EQ,
  output logic GT
);

  logic [1:0] w_a;
  logic [1:0] w_b;

  assign w_a = {a1, a0};
  assign w_b = {b1, b0};

  // Differing digit decides; equal digit passes the lower-order result through.
  always_comb begin
    EQ = eq;
    GT = gt;
    if (w_a > w_b) begin
      EQ = 1'b0;
      GT = 1'b1;
    end else if (w_a < w_b) begin
      EQ = 1'b0;
      GT = 1'b0;
    end
  end

endmodule

// File: rtl/cmp_serial_rx.sv
// Digit-serial magnitude comparator, LSB digit first, seeded like the parallel cascade.
// Optional feature macro: CMP_SERIAL_ABORT_EN (adds an abort input honoured in RUN).
module cmp_serial_rx
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  cmp_serial_rx_if.slave  bus
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  cmp_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_eq;
  logic             r_gt;
  logic             r_dig_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_res_eq;
  logic             r_res_gt;

  logic             w_cell_eq;
  logic             w_cell_gt;
  logic             w_accept;
  logic             w_abort;
  logic             w_last;

`ifdef CMP_SERIAL_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = (r_state == RUN) && r_dig_ready && bus.dig_valid;
  assign w_last   = (r_cnt == CNT_W'(DIGITS - 1));

  cmp2_cell u_cell (
    .a1 (bus.a_dig[1]),
    .a0 (bus.a_dig[0]),
    .b1 (bus.b_dig[1]),
    .b0 (bus.b_dig[0]),
    .eq (r_eq),
    .gt (r_gt),
    .EQ (w_cell_eq),
    .GT (w_cell_gt)
  );

  // Comparator FSM; all handshake and result outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_eq        <= 1'b0;
      r_gt        <= 1'b0;
      r_dig_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_res_eq    <= 1'b0;
      r_res_gt    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_eq        <= bus.eq_in;
            r_gt        <= bus.gt_in;
            r_cnt       <= '0;
            r_state     <= RUN;
            r_dig_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_state     <= IDLE;
            r_dig_ready <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_accept) begin
            r_eq <= w_cell_eq;
            r_gt <= w_cell_gt;
            if (w_last) begin
              // Result becomes visible together with the done pulse.
              r_state     <= DONE;
              r_dig_ready <= 1'b0;
              r_done      <= 1'b1;
              r_res_eq    <= w_cell_eq;
              r_res_gt    <= w_cell_gt;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_dig_ready <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dig_ready = r_dig_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.EQ        = r_res_eq;
  assign bus.GT        = r_res_gt;

endmodule

// File: tb/tb_cmp_serial_rx.sv
// Directed scoreboard bench for cmp_serial_rx (WIDTH=8, LSB-first digits).
module tb_cmp_serial_rx;
  import cmp_pkg::*;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DIGITS = WIDTH / 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cmp_serial_rx_if bus ();

  cmp_serial_rx #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  logic [1:0] last_res;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: plain integer compare, seeds only matter when operands are equal.
  function automatic logic [1:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic se, input logic sg);
    if (a > b)      return 2'b01;
    else if (a < b) return 2'b00;
    else            return {se, sg};
  endfunction

  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic se, input logic sg,
                         input bit stall_alt, input bit hold_start);
    int         cyc;
    int         d;
    logic [1:0] exp;
    exp_q.push_back(model(a, b, se, sg));
    bus.start = 1'b1;
    bus.eq_in = se;
    bus.gt_in = sg;
    tick();
    cyc = 1;
    bus.start = hold_start;
    check({tag, "_busy_run"}, bus.busy, 1'b1);
    check({tag, "_ready_run"}, bus.dig_ready, 1'b1);
    d = 0;
    while (d < int'(DIGITS) && cyc < 64) begin
      bus.dig_valid = stall_alt ? (cyc % 2 == 0) : 1'b1;
      bus.a_dig     = a[2*d +: 2];
      bus.b_dig     = b[2*d +: 2];
      if (bus.dig_valid) d++;
      tick();
      cyc++;
      if (d < int'(DIGITS)) begin
        check({tag, "_no_early_done"}, bus.done, 1'b0);
        check({tag, "_eq_hold"}, bus.EQ, last_res[1]);
        check({tag, "_gt_hold"}, bus.GT, last_res[0]);
      end
    end
    bus.dig_valid = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_done"}, bus.done, 1'b1);
    exp = exp_q.pop_front();
    check({tag, "_EQ"}, bus.EQ, exp[1]);
    check({tag, "_GT"}, bus.GT, exp[0]);
    check({tag, "_busy_done"}, bus.busy, 1'b1);
    check({tag, "_ready_done"}, bus.dig_ready, 1'b0);
    last_res = exp;
    tick();
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.eq_in     = 1'b0;
    bus.gt_in     = 1'b0;
    bus.a_dig     = 2'd0;
    bus.b_dig     = 2'd0;
    bus.dig_valid = 1'b0;
`ifdef CMP_SERIAL_ABORT_EN
    bus.abort     = 1'b0;
`endif
    last_res = 2'b00;
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.dig_ready, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_EQ", bus.EQ, 1'b0);
    check("rst_GT", bus.GT, 1'b0);
    rst = 1'b0;
    tick();

    // Equal operands, seed passes through.
    run_cmp("t1_eq", 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    // Top digit decides; start held high through RUN must not restart the count.
    run_cmp("t2_msb", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1);
    // Less-than with alternate-cycle stalls: done lands on cycle 9.
    run_cmp("t3_stall", 8'h12, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0);
    // Seed propagation, then back-to-back start right after done.
    run_cmp("t4_seed", 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    run_cmp("t4_b2b", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    run_cmp("t4_ltmsb", 8'h3F, 8'hC0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset mid-RUN with a prior EQ=1 result on the outputs.
    run_cmp("t5_pre", 8'h55, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.eq_in = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.dig_valid = 1'b1;
      bus.a_dig     = 2'd1;
      bus.b_dig     = 2'd1;
      tick();
    end
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.dig_valid = 1'b0;
    check("t5_busy", bus.busy, 1'b0);
    check("t5_ready", bus.dig_ready, 1'b0);
    check("t5_EQ", bus.EQ, 1'b0);
    check("t5_GT", bus.GT, 1'b0);
    check("t5_done", bus.done, 1'b0);
    tick();
    check("t5_no_done", bus.done, 1'b0);
    check("t5_idle", bus.busy, 1'b0);
    last_res = 2'b00;
    run_cmp("t5_fresh", 8'hFF, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef CMP_SERIAL_ABORT_EN
    // Abort after three digits: no done, previous EQ=1 kept.
    run_cmp("t6_pre", 8'h9C, 8'h9C, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.eq_in = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.dig_valid = 1'b1;
      bus.a_dig     = 2'd3;
      bus.b_dig     = 2'd0;
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort     = 1'b0;
    bus.start     = 1'b0;
    bus.dig_valid = 1'b0;
    check("t6_busy", bus.busy, 1'b0);
    check("t6_ready", bus.dig_ready, 1'b0);
    check("t6_done", bus.done, 1'b0);
    check("t6_EQ", bus.EQ, 1'b1);
    check("t6_GT", bus.GT, 1'b0);
    tick();
    check("t6_no_done", bus.done, 1'b0);
    run_cmp("t6_after", 8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
